// File: rtl/mips_multi.sv
// Multicycle MIPS-subset core on a single instruction/data bus.
// States FETCH, DECODE, EXEC, MEM, WB, HALT; at most one memory transfer in flight.
module mips_multi #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm;
  logic [31:0] r_target;
  logic [31:0] r_alu;
  logic [31:0] r_mdr;
  logic [31:0] r_retired;
  logic [31:0] r_regs [32];

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_simm;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_simm   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_j, w_is_jal, w_is_halt;
  logic w_is_jr, w_r_alu_ok;

  assign w_is_r     = (w_op == 6'h00);
  assign w_is_lw    = (w_op == 6'h23);
  assign w_is_sw    = (w_op == 6'h2B);
  assign w_is_beq   = (w_op == 6'h04);
  assign w_is_addi  = (w_op == 6'h08);
  assign w_is_j     = (w_op == 6'h02);
  assign w_is_jal   = (w_op == 6'h03);
  assign w_is_halt  = (w_op == 6'h3F);
  assign w_is_jr    = w_is_r && (w_funct == 6'h08);
  assign w_r_alu_ok = w_is_r && ((w_funct == 6'h20) || (w_funct == 6'h22) ||
                                 (w_funct == 6'h24) || (w_funct == 6'h25) ||
                                 (w_funct == 6'h2A));

  logic [31:0] w_alu;
  always_comb begin
    w_alu = r_a + r_imm;
    if (w_is_r) begin
      case (w_funct)
        6'h20:   w_alu = r_a + r_b;
        6'h22:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h2A:   w_alu = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
        default: w_alu = 32'd0;
      endcase
    end
  end

  // Bus outputs are forced idle while rst is high, even before the reset edge.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = r_pc[ADDR_W-1:0];
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_we    = w_is_sw;
          mem_addr  = r_alu[ADDR_W-1:0];
          mem_wdata = w_is_sw ? r_b : 32'd0;
        end
        default: ;
      endcase
    end
  end

  logic w_hs;
  logic w_retire;
  assign w_hs = mem_req && mem_ready;

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_DECODE: w_retire = !w_is_halt && !(w_r_alu_ok || w_is_lw || w_is_sw ||
                                           w_is_beq || w_is_addi);
      S_EXEC:   w_retire = w_is_beq;
      S_MEM:    w_retire = w_hs && w_is_sw;
      S_WB:     w_retire = 1'b1;
      default:  w_retire = 1'b0;
    endcase
  end

  logic [4:0]  w_wb_dst;
  logic [31:0] w_wb_val;
  assign w_wb_dst = w_is_r ? w_rd : w_rt;
  assign w_wb_val = w_is_lw ? r_mdr : r_alu;

  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_imm     <= 32'd0;
      r_target  <= 32'd0;
      r_alu     <= 32'd0;
      r_mdr     <= 32'd0;
      r_retired <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      if (w_retire) r_retired <= r_retired + 32'd1;
      case (r_state)
        S_FETCH: begin
          if (w_hs) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + 32'd4;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a      <= w_rs_val;
          r_b      <= w_rt_val;
          r_imm    <= w_simm;
          r_target <= r_pc + {w_simm[29:0], 2'b00};
          if (w_is_halt) begin
            r_state <= S_HALT;
          end else if (w_is_j || w_is_jal) begin
            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            if (w_is_jal) r_regs[31] <= r_pc;
            r_state <= S_FETCH;
          end else if (w_is_jr) begin
            r_pc    <= w_rs_val;
            r_state <= S_FETCH;
          end else if (w_r_alu_ok || w_is_lw || w_is_sw || w_is_beq || w_is_addi) begin
            r_state <= S_EXEC;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_is_beq) begin
            if (r_a == r_b) r_pc <= r_target;
            r_state <= S_FETCH;
          end else if (w_is_lw || w_is_sw) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (w_hs) begin
            if (w_is_sw) begin
              r_state <= S_FETCH;
            end else begin
              r_mdr   <= mem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= w_wb_val;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi.sv
// Self-checking bench for mips_multi: table-driven instruction vectors plus
// directed sequences for stalls, branches, jumps, halt and reset mid-store.
module tb_mips_multi;
  localparam int unsigned AW  = 12;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          halted;
  logic [31:0]   retired;

  logic [31:0] mem [1024];
  int          wait_rd = 0;
  int          wait_wr = 0;
  int          stall_cnt = 0;
  int          n_wr = 0;
  logic [31:0] last_wa = 32'd0;
  logic [31:0] last_wd = 32'd0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mips_multi #(
    .ADDR_W  (AW),
    .RESET_PC(RPC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .halted   (halted),
    .retired  (retired)
  );

  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = mem_req && (stall_cnt >= (mem_we ? wait_wr : wait_rd));

  always @(posedge clk) begin
    if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[11:2]] = mem_wdata;
      n_wr    = n_wr + 1;
      last_wa = 32'(mem_addr);
      last_wd = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Request signals must hold while a transfer is stalled.
  logic          p_stall = 1'b0;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [31:0]   p_wdata;
  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_req", {31'd0, mem_req}, 32'd1);
        chk("stall_we", {31'd0, mem_we}, {31'd0, p_we});
        chk("stall_addr", 32'(mem_addr), 32'(p_addr));
        chk("stall_wdata", mem_wdata, p_wdata);
      end
      p_stall = mem_req && !mem_ready;
      p_we    = mem_we;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  task automatic clear_mem;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // Cycles until retired changes; -1 when the bound expires.
  task automatic step(output int cyc);
    logic [31:0] p;
    p   = retired;
    cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (retired != p) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Cycle number (1 = first cycle after reset) in which halted is first seen.
  task automatic wait_halt(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (halted) begin
        cyc = c + 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic [4:0]  rg;
    logic [31:0] val;
  } vec_t;

  vec_t vt[19];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;

    vt[0]  = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5),     4, 5'd1,  32'd5};
    vt[1]  = '{enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),  4, 5'd2,  32'hFFFF_FFFD};
    vt[2]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20),      4, 5'd3,  32'd2};
    vt[3]  = '{enc_r(5'd1, 5'd2, 5'd4, 6'h22),      4, 5'd4,  32'd8};
    vt[4]  = '{enc_r(5'd1, 5'd2, 5'd5, 6'h24),      4, 5'd5,  32'd5};
    vt[5]  = '{enc_r(5'd1, 5'd2, 5'd6, 6'h25),      4, 5'd6,  32'hFFFF_FFFD};
    vt[6]  = '{enc_r(5'd2, 5'd1, 5'd7, 6'h2A),      4, 5'd7,  32'd1};
    vt[7]  = '{enc_r(5'd1, 5'd2, 5'd8, 6'h2A),      4, 5'd8,  32'd0};
    vt[8]  = '{enc_i(6'h08, 5'd0, 5'd0, 16'd7),     4, 5'd0,  32'd0};
    vt[9]  = '{enc_i(6'h08, 5'd0, 5'd9, 16'hFFFF),  4, 5'd9,  32'hFFFF_FFFF};
    vt[10] = '{enc_i(6'h08, 5'd0, 5'd10, 16'd1),    4, 5'd10, 32'd1};
    vt[11] = '{enc_r(5'd9, 5'd10, 5'd11, 6'h2A),    4, 5'd11, 32'd1};
    vt[12] = '{enc_r(5'd9, 5'd10, 5'd12, 6'h20),    4, 5'd12, 32'd0};
    vt[13] = '{enc_i(6'h04, 5'd1, 5'd2, 16'd5),     3, 5'd1,  32'd5};
    vt[14] = '{32'hF800_0000,                       2, 5'd0,  32'd0};
    vt[15] = '{enc_r(5'd1, 5'd2, 5'd13, 6'h27),     2, 5'd13, 32'd0};
    vt[16] = '{enc_i(6'h2B, 5'd0, 5'd3, 16'd8),     4, 5'd3,  32'd2};
    vt[17] = '{enc_i(6'h23, 5'd0, 5'd14, 16'd8),    5, 5'd14, 32'd2};
    vt[18] = '{enc_j(6'h02, 26'h53),                2, 5'd0,  32'd0};

    // Table-driven straight-line program at RESET_PC.
    clear_mem();
    for (int i = 0; i < 19; i++) mem[64 + i] = vt[i].instr;
    mem[64 + 19] = HALT_I;
    n_wr = 0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    do_reset();
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_we", {31'd0, mem_we}, 32'd0);
    chk("post_rst_addr", 32'(mem_addr), RPC);
    for (int i = 0; i < 19; i++) begin
      step(cyc);
      chk($sformatf("vec%0d_lat", i), 32'(cyc), 32'(vt[i].lat));
      chk($sformatf("vec%0d_reg", i), dut.r_regs[vt[i].rg], vt[i].val);
      chk($sformatf("vec%0d_next", i), 32'(mem_addr), RPC + 32'(4 * (i + 1)));
    end
    chk("vec_retired", retired, 32'd19);
    chk("vec_nwr", 32'(n_wr), 32'd1);
    chk("vec_wa", last_wa, 32'd8);
    chk("vec_wd", last_wd, 32'd2);

    // addi/addi/add/halt: halted in cycle 15 with three retirements.
    clear_mem();
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[66] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[67] = HALT_I;
    do_reset();
    wait_halt(cyc);
    chk("halt_cycle", 32'(cyc), 32'd15);
    chk("halt_r3", dut.r_regs[3], 32'd2);
    chk("halt_retired", retired, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("halt_stays", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, mem_req}, 32'd0);
    chk("halt_retired2", retired, 32'd3);

    // Store then load with three wait cycles on every access.
    clear_mem();
    mem[64] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
    mem[65] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
    mem[66] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    mem[67] = HALT_I;
    wait_rd = 3;
    wait_wr = 3;
    do_reset();
    n_wr = 0;
    step(cyc);
    chk("stl_addi_lat", 32'(cyc), 32'd7);
    step(cyc);
    chk("stl_sw_lat", 32'(cyc), 32'd10);
    step(cyc);
    chk("stl_lw_lat", 32'(cyc), 32'd11);
    chk("stl_nwr", 32'(n_wr), 32'd1);
    chk("stl_wa", last_wa, 32'd8);
    chk("stl_wd", last_wd, 32'd2);
    chk("stl_r4", dut.r_regs[4], 32'd2);
    wait_rd = 0;
    wait_wr = 0;

    // beq taken with imm=-1 loops to itself; not taken falls through.
    clear_mem();
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd4);
    mem[65] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    do_reset();
    step(cyc);
    step(cyc);
    chk("beq_t_lat", 32'(cyc), 32'd3);
    chk("beq_t_pc", 32'(mem_addr), 32'h104);
    clear_mem();
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd4);
    mem[65] = enc_i(6'h04, 5'd1, 5'd0, 16'hFFFF);
    do_reset();
    step(cyc);
    step(cyc);
    chk("beq_n_lat", 32'(cyc), 32'd3);
    chk("beq_n_pc", 32'(mem_addr), 32'h108);

    // jal to 0x40, jr $31 back to the instruction after jal.
    clear_mem();
    mem[64] = enc_j(6'h03, 26'h10);
    mem[16] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    mem[65] = HALT_I;
    do_reset();
    step(cyc);
    chk("jal_lat", 32'(cyc), 32'd2);
    chk("jal_pc", 32'(mem_addr), 32'h40);
    chk("jal_r31", dut.r_regs[31], 32'h104);
    step(cyc);
    chk("jr_lat", 32'(cyc), 32'd2);
    chk("jr_pc", 32'(mem_addr), 32'h104);
    wait_halt(cyc);
    chk("jr_halted", {31'd0, halted}, 32'd1);
    chk("jr_retired", retired, 32'd2);

    // Reset during a stalled store: the store never completes.
    clear_mem();
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[65] = enc_i(6'h2B, 5'd0, 5'd1, 16'd16);
    wait_wr = 40;
    do_reset();
    n_wr = 0;
    step(cyc);
    chk("rmem_addi_lat", 32'(cyc), 32'd4);
    cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_we) begin
        cyc = c;
        break;
      end
    end
    chk("rmem_reach_mem", {31'd0, (cyc >= 0)}, 32'd1);
    @(posedge clk);
    #1;
    chk("rmem_pending", {31'd0, mem_req && mem_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmem_req", {31'd0, mem_req}, 32'd0);
    chk("rmem_we", {31'd0, mem_we}, 32'd0);
    chk("rmem_addr", 32'(mem_addr), 32'd0);
    chk("rmem_wdata", mem_wdata, 32'd0);
    chk("rmem_retired", retired, 32'd0);
    chk("rmem_r1", dut.r_regs[1], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rmem_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("rmem_fetch_addr", 32'(mem_addr), RPC);
    chk("rmem_nwr", 32'(n_wr), 32'd0);
    chk("rmem_mem4", mem[4], 32'd0);
    wait_wr = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
